ahb_sdram_wbuf: RTL

Parametrised AHB-Lite slave front-end for the SDRAM controller. It adds a posted-write buffer, byte-lane generation for any DATA_W, and ERROR responses for illegal transfers. Upstream is the AHB-Lite bus. Downstream is a valid/ready single-beat memory request port with a separate read-return strobe. Reads are strictly ordered behind buffered writes.

---
 rtl/ahb_sdram_wbuf.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ahb_sdram_wbuf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ahb_sdram_wbuf : AHB-Lite slave front-end with posted-write FIFO for SDRAM
// Revision 1.0
// ----------------------------------------------------------------------------
module ahb_sdram_wbuf #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int WBUF_DEPTH = 4,
   parameter int CNT_W      = $clog2(WBUF_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hsel,
   input  logic [ADDR_W-1:0]     haddr,
   input  logic                  hwrite,
   input  logic [1:0]            htrans,
   input  logic [2:0]            hsize,
   input  logic [DATA_W-1:0]     hwdata,
   input  logic                  hready,
   output logic [DATA_W-1:0]     hrdata,
   output logic                  hreadyout,
   output logic                  hresp,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic                  req_we,
   output logic [ADDR_W-1:0]     req_addr,
   output logic [DATA_W-1:0]     req_wdata,
   output logic [DATA_W/8-1:0]   req_be,
   input  logic                  rd_valid,
   input  logic [DATA_W-1:0]     rd_data,
   output logic [CNT_W-1:0]      wbuf_count
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int PTR_W = $clog2(WBUF_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_WDATA, S_RD_DRAIN, S_RD_REQ, S_RD_WAIT, S_ERR1, S_ERR2
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [NB-1:0]       be_q;
   logic                hready_q;
   logic                hresp_q;
   logic [DATA_W-1:0]   hrdata_q;
   logic [PTR_W-1:0]    wptr_q;
   logic [PTR_W-1:0]    rptr_q;
   logic [CNT_W-1:0]    count_q;
   logic [ADDR_W-1:0]   fifo_addr_q [WBUF_DEPTH];
   logic [NB-1:0]       fifo_be_q   [WBUF_DEPTH];
   logic [DATA_W-1:0]   fifo_data_q [WBUF_DEPTH];

   logic                w_accept, w_legal, w_wr_req, w_pop, w_push_ok, w_push, w_slot;
   logic [NB-1:0]       w_be;
   logic [ADDR_W-1:0]   w_addr_al;

   assign w_accept  = hsel & hready & htrans[1];
   assign w_addr_al = {haddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   always_comb begin
      w_legal = (hsize <= 3'(OFF_W));
      w_be    = '0;
      for (int i = 0; i < OFF_W; i++)
         if (i < int'(hsize) && haddr[i]) w_legal = 1'b0;
      for (int i = 0; i < NB; i++)
         if (i >= int'(haddr[OFF_W-1:0]) && i < int'(haddr[OFF_W-1:0]) + (1 << hsize))
            w_be[i] = 1'b1;
   end

   // Writes drain whenever the read path does not own the request port.
   assign w_wr_req  = (count_q != '0) && (state_q != S_RD_REQ) && (state_q != S_RD_WAIT);
   assign w_pop     = w_wr_req & req_ready;
   assign w_push_ok = (count_q < CNT_W'(WBUF_DEPTH)) | w_pop;
   assign w_push    = (state_q == S_WDATA) & w_push_ok;
   assign w_slot    = (state_q == S_IDLE) | (state_q == S_ERR2) | w_push;

   assign hreadyout  = (state_q == S_WDATA) ? w_push_ok : hready_q;
   assign hresp      = hresp_q;
   assign hrdata     = hrdata_q;
   assign req_valid  = w_wr_req | (state_q == S_RD_REQ);
   assign req_we     = w_wr_req;
   assign wbuf_count = count_q;

   always_comb begin
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      if (w_wr_req) begin
         req_addr  = fifo_addr_q[rptr_q];
         req_wdata = fifo_data_q[rptr_q];
         req_be    = fifo_be_q[rptr_q];
      end else if (state_q == S_RD_REQ) begin
         req_addr  = addr_q;
         req_be    = be_q;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         fifo_addr_q[wptr_q] <= addr_q;
         fifo_be_q[wptr_q]   <= be_q;
         fifo_data_q[wptr_q] <= hwdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         be_q     <= '0;
         hready_q <= 1'b1;
         hresp_q  <= 1'b0;
         hrdata_q <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) wptr_q <= wptr_q + 1'b1;
         if (w_pop)  rptr_q <= rptr_q + 1'b1;
         case ({w_push, w_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase

         if (w_slot & w_accept) begin
            addr_q <= w_addr_al;
            be_q   <= w_be;
         end

         if (w_slot) begin
            if (!w_accept) begin
               state_q  <= S_IDLE;
               hready_q <= 1'b1;
               hresp_q  <= 1'b0;
            end else if (!w_legal) begin
               state_q  <= S_ERR1;
               hready_q <= 1'b0;
               hresp_q  <= 1'b1;
            end else if (hwrite) begin
               state_q  <= S_WDATA;
               hready_q <= 1'b1;
               hresp_q  <= 1'b0;
            end else begin
               state_q  <= S_RD_DRAIN;
               hready_q <= 1'b0;
               hresp_q  <= 1'b0;
            end
         end else begin
            case (state_q)
               S_RD_DRAIN: if (count_q == '0) state_q <= S_RD_REQ;
               S_RD_REQ:   if (req_ready) state_q <= S_RD_WAIT;
               S_RD_WAIT: begin
                  if (rd_valid) begin
                     hrdata_q <= rd_data;
                     hready_q <= 1'b1;
                     state_q  <= S_IDLE;
                  end
               end
               S_ERR1: begin
                  state_q  <= S_ERR2;
                  hready_q <= 1'b1;
               end
               default: state_q <= state_q;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
